// File: rtl/qed_i_cache.sv
// QED instruction replay buffer: captures modified instructions in the original phase and replays them in order for the duplicate phase.
// Optional: define QIC_AUTO_DUP_EN to enter replay automatically when the buffer fills.
module qed_i_cache #(
   parameter int unsigned DEPTH    = 16,
   parameter logic [31:0] NOP_INSN = 32'h0000_0013
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    ena,
   input  logic                    exec_dup,
   input  logic                    stall_IF,
   input  logic [31:0]             qed_instruction,
   input  logic                    qed_insn_valid,
   output logic [31:0]             qic_qimux_instruction,
   output logic                    vld_out,
   output logic                    qed_ready,
   output logic [$clog2(DEPTH):0]  num_orig,
   output logic [$clog2(DEPTH):0]  num_dup,
   output logic                    overflow
);

   localparam int unsigned ADDR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W  = ADDR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   typedef enum logic [1:0] {
      S_ORIG = 2'd0,
      S_DUP  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t              r_state;
   logic [31:0]         r_mem [DEPTH];
   logic [ADDR_W-1:0]   r_wr_ptr;
   logic [ADDR_W-1:0]   r_rd_ptr;
   logic [CNT_W-1:0]    r_count;
   logic [CNT_W-1:0]    r_num_orig;
   logic [CNT_W-1:0]    r_num_dup;
   logic                r_overflow;
   logic                r_vld;
   logic                r_qed_ready;

   logic                w_advance;
   logic                w_full;
   logic                w_push;

   assign w_advance = ena && !stall_IF;
   assign w_full    = (r_count == FULL_CNT);
   // exec_dup wins over a same-cycle capture
   assign w_push    = w_advance && (r_state == S_ORIG) && !exec_dup
                      && qed_insn_valid && !w_full;

   // Storage is intentionally left unreset
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= qed_instruction;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_ORIG;
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
         r_num_orig  <= '0;
         r_num_dup   <= '0;
         r_overflow  <= 1'b0;
         r_vld       <= 1'b0;
         r_qed_ready <= 1'b0;
      end else if (w_advance) begin
         case (r_state)
            S_ORIG: begin
               if (exec_dup) begin
                  if (r_count != '0) begin
                     r_state <= S_DUP;
                     r_vld   <= 1'b1;
                  end else begin
                     r_state     <= S_DONE;
                     r_qed_ready <= 1'b1;
                  end
               end
`ifdef QIC_AUTO_DUP_EN
               else if (w_full) begin
                  r_state <= S_DUP;
                  r_vld   <= 1'b1;
               end
`endif
               else if (qed_insn_valid) begin
                  if (w_full) begin
                     r_overflow <= 1'b1;
                  end else begin
                     r_wr_ptr   <= r_wr_ptr + ADDR_W'(1);
                     r_count    <= r_count + CNT_W'(1);
                     r_num_orig <= r_num_orig + CNT_W'(1);
                  end
               end
            end
            S_DUP: begin
               r_rd_ptr  <= r_rd_ptr + ADDR_W'(1);
               r_count   <= r_count - CNT_W'(1);
               r_num_dup <= r_num_dup + CNT_W'(1);
               if (r_count == CNT_W'(1)) begin
                  r_state     <= S_DONE;
                  r_vld       <= 1'b0;
                  r_qed_ready <= 1'b1;
               end
            end
            default: begin
               r_state <= S_DONE;
            end
         endcase
      end
   end

   assign qic_qimux_instruction = r_vld ? r_mem[r_rd_ptr] : NOP_INSN;
   assign vld_out               = r_vld;
   assign qed_ready             = r_qed_ready;
   assign num_orig              = r_num_orig;
   assign num_dup               = r_num_dup;
   assign overflow              = r_overflow;

endmodule

// File: tb/tb_qed_i_cache.sv
// Directed self-checking bench for qed_i_cache; expectations follow QIC_AUTO_DUP_EN when defined.
module tb_qed_i_cache;

   localparam int unsigned DEPTH = 16;
   localparam logic [31:0] NOP   = 32'h0000_0013;

   logic        clk;
   logic        rst;
   logic        ena;
   logic        exec_dup;
   logic        stall_IF;
   logic [31:0] qed_instruction;
   logic        qed_insn_valid;
   logic [31:0] qic_qimux_instruction;
   logic        vld_out;
   logic        qed_ready;
   logic [4:0]  num_orig;
   logic [4:0]  num_dup;
   logic        overflow;

   int n_checks;
   int n_errors;

   qed_i_cache #(.DEPTH(DEPTH), .NOP_INSN(NOP)) dut (
      .clk                   (clk),
      .rst                   (rst),
      .ena                   (ena),
      .exec_dup              (exec_dup),
      .stall_IF              (stall_IF),
      .qed_instruction       (qed_instruction),
      .qed_insn_valid        (qed_insn_valid),
      .qic_qimux_instruction (qic_qimux_instruction),
      .vld_out               (vld_out),
      .qed_ready             (qed_ready),
      .num_orig              (num_orig),
      .num_dup               (num_dup),
      .overflow              (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
      end
   endtask

   // Drive one cycle of inputs, then sample 1 time unit after the edge
   task automatic step(input logic v, input logic [31:0] insn, input logic xd,
                       input logic st, input logic en);
      qed_insn_valid  = v;
      qed_instruction = insn;
      exec_dup        = xd;
      stall_IF        = st;
      ena             = en;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic check_idle(input string tag, input logic [31:0] n_o, input logic ovf);
      check({tag, "_vld"},  32'(vld_out), 32'd0);
      check({tag, "_insn"}, qic_qimux_instruction, NOP);
      check({tag, "_rdy"},  32'(qed_ready), 32'd0);
      check({tag, "_norig"}, 32'(num_orig), n_o);
      check({tag, "_ovf"},  32'(overflow), 32'(ovf));
   endtask

   logic [31:0] prog [3];

   initial begin
      n_checks = 0;
      n_errors = 0;
      prog[0] = 32'h00A0_0093;
      prog[1] = 32'h0010_8113;
      prog[2] = 32'h0020_81B3;
      ena = 1'b1; exec_dup = 1'b0; stall_IF = 1'b0;
      qed_instruction = '0; qed_insn_valid = 1'b0;
      rst = 1'b0;
      #2;
      do_reset();

      // Reset state
      check_idle("rst", 32'd0, 1'b0);
      check("rst_ndup", 32'(num_dup), 32'd0);

      // Capture three instructions; ena=0 and stall cycles must not capture
      step(1'b1, prog[0], 1'b0, 1'b0, 1'b1);
      step(1'b1, 32'hDEAD_0001, 1'b0, 1'b0, 1'b0);
      check("ena0_norig", 32'(num_orig), 32'd1);
      step(1'b1, 32'hDEAD_0002, 1'b0, 1'b1, 1'b1);
      check("stall_orig_norig", 32'(num_orig), 32'd1);
      step(1'b1, prog[1], 1'b0, 1'b0, 1'b1);
      step(1'b0, 32'hDEAD_0003, 1'b0, 1'b0, 1'b1);
      step(1'b1, prog[2], 1'b0, 1'b0, 1'b1);
      check_idle("cap3", 32'd3, 1'b0);

      // exec_dup with a same-cycle valid instruction: not captured
      step(1'b1, 32'hDEAD_0004, 1'b1, 1'b0, 1'b1);
      check("xd_norig", 32'(num_orig), 32'd3);
      check("dup0_vld", 32'(vld_out), 32'd1);
      check("dup0_insn", qic_qimux_instruction, prog[0]);
      check("dup0_ndup", 32'(num_dup), 32'd0);
      step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
      check("dup1_insn", qic_qimux_instruction, prog[1]);
      check("dup1_ndup", 32'(num_dup), 32'd1);

      // Stall on entry 2 for four cycles
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 32'hDEAD_0005, 1'b1, 1'b1, 1'b1);
         check($sformatf("stall%0d_insn", i), qic_qimux_instruction, prog[1]);
         check($sformatf("stall%0d_ndup", i), 32'(num_dup), 32'd1);
         check($sformatf("stall%0d_vld", i), 32'(vld_out), 32'd1);
      end
      step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
      check("dup2_insn", qic_qimux_instruction, prog[2]);
      check("dup2_ndup", 32'(num_dup), 32'd2);
      step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
      check("done_vld", 32'(vld_out), 32'd0);
      check("done_insn", qic_qimux_instruction, NOP);
      check("done_rdy", 32'(qed_ready), 32'd1);
      check("done_ndup", 32'(num_dup), 32'd3);
      step(1'b1, 32'hDEAD_0006, 1'b1, 1'b0, 1'b1);
      check("done_hold_rdy", 32'(qed_ready), 32'd1);
      check("done_hold_norig", 32'(num_orig), 32'd3);
      check("done_hold_vld", 32'(vld_out), 32'd0);

      // Reset mid-replay after 2 of 5 pops
      do_reset();
      for (int i = 0; i < 5; i++) step(1'b1, 32'h2000_0000 + 32'(i), 1'b0, 1'b0, 1'b1);
      step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
      step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
      step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
      check("mid_insn", qic_qimux_instruction, 32'h2000_0002);
      check("mid_ndup", 32'(num_dup), 32'd2);
      rst = 1'b1;
      #2;
      check_idle("midrst", 32'd0, 1'b0);
      check("midrst_ndup", 32'(num_dup), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      step(1'b1, 32'h3000_0000, 1'b0, 1'b0, 1'b1);
      check("midrst_orig_norig", 32'(num_orig), 32'd1);
      check("midrst_orig_vld", 32'(vld_out), 32'd0);

      // exec_dup with an empty buffer
      do_reset();
      step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
      check("empty_vld", 32'(vld_out), 32'd0);
      check("empty_rdy", 32'(qed_ready), 32'd1);
      check("empty_insn", qic_qimux_instruction, NOP);
      step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
      check("empty_vld2", 32'(vld_out), 32'd0);

      // Fill past capacity, then replay the first DEPTH entries
      do_reset();
      for (int i = 0; i < 16; i++) step(1'b1, 32'h1000_0000 + 32'(i), 1'b0, 1'b0, 1'b1);
      check_idle("full", 32'd16, 1'b0);
`ifdef QIC_AUTO_DUP_EN
      step(1'b1, 32'hBAD0_0010, 1'b0, 1'b0, 1'b1);
      check("auto_vld", 32'(vld_out), 32'd1);
      check("auto_ovf", 32'(overflow), 32'd0);
      check("auto_norig", 32'(num_orig), 32'd16);
`else
      for (int i = 0; i < 4; i++) step(1'b1, 32'hBAD0_0010 + 32'(i), 1'b0, 1'b0, 1'b1);
      check_idle("ovf", 32'd16, 1'b1);
      step(1'b0, 32'h0, 1'b1, 1'b0, 1'b1);
      check("ovf_dup_vld", 32'(vld_out), 32'd1);
`endif
      for (int i = 0; i < 16; i++) begin
         check($sformatf("wrap%0d_insn", i), qic_qimux_instruction, 32'h1000_0000 + 32'(i));
         check($sformatf("wrap%0d_ndup", i), 32'(num_dup), 32'(i));
         step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
      end
      check("wrap_done_rdy", 32'(qed_ready), 32'd1);
      check("wrap_done_vld", 32'(vld_out), 32'd0);
      check("wrap_done_ndup", 32'(num_dup), 32'd16);
`ifdef QIC_AUTO_DUP_EN
      check("wrap_done_ovf", 32'(overflow), 32'd0);
`else
      check("wrap_done_ovf", 32'(overflow), 32'd1);
`endif

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
